// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point special-operand front end:
// operand class codes, op codes and a width-generic quiet-NaN builder.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'b000,
    CLS_SUB  = 3'b001,
    CLS_NORM = 3'b011,
    CLS_INF  = 3'b100,
    CLS_NAN  = 3'b110
  } fp_class_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int FP_MAX_W = 128;

  // Right-aligned canonical qNaN: sign 0, exponent all-ones, mantissa MSB only.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < FP_MAX_W; i++) begin
      if ((i >= man_w - 1) && (i < man_w + exp_w)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier (zero/subnormal/normal/inf/NaN).
// Build option FP_SUBNORMAL_FLUSH_EN classifies subnormals as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] man_i,
  output logic [2:0]       class_o
);

  always_comb begin
    class_o = CLS_NORM;
    if (exp_i == '0) begin
      if (man_i == '0) begin
        class_o = CLS_ZERO;
      end else begin
`ifdef FP_SUBNORMAL_FLUSH_EN
        class_o = CLS_ZERO;
`else
        class_o = CLS_SUB;
`endif
      end
    end else if (&exp_i) begin
      class_o = (man_i == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage special-operand resolver for FP add/sub/mul with valid/ready flow,
// sticky invalid flag and saturating special-beat counter. Option: FP_SUBNORMAL_FLUSH_EN.
module fp_special_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_special,
  output logic             out_invalid,
  output logic [2:0]       out_class_a,
  output logic [2:0]       out_class_b,
  output logic             flag_invalid,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] special_cnt
);

  localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]        INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [2:0]       cls_a, cls_b;
  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [W-1:0]     a_p1_q, b_p1_q;
  logic [1:0]       op_p1_q;
  logic [2:0]       cla_p1_q, clb_p1_q, cla_p2_q, clb_p2_q;
  logic [W-1:0]     res_d, res_p2_q;
  logic             spc_d, spc_p2_q, inv_d, inv_p2_q;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv_p2, acc_in, acc_out;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp_i(a[W-2:MAN_W]), .man_i(a[MAN_W-1:0]), .class_o(cls_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp_i(b[W-2:MAN_W]), .man_i(b[MAN_W-1:0]), .class_o(cls_b)
  );

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !rst && (!vld_p1_q || adv_p2);
  assign acc_in   = in_valid && in_ready;
  assign acc_out  = vld_p2_q && out_ready;

  // Stage 1: register operands, op and classes
  always_ff @(posedge clk) begin
    if (acc_in) begin
      a_p1_q   <= a;
      b_p1_q   <= b;
      op_p1_q  <= op;
      cla_p1_q <= cls_a;
      clb_p1_q <= cls_b;
    end
  end

  always_comb begin
    logic sa, sbe, sm, na, nb, ia, ib, za, zb;
    sa  = a_p1_q[W-1];
    sbe = b_p1_q[W-1] ^ op_p1_q[0];
    sm  = a_p1_q[W-1] ^ b_p1_q[W-1];
    na  = (cla_p1_q == CLS_NAN);
    nb  = (clb_p1_q == CLS_NAN);
    ia  = (cla_p1_q == CLS_INF);
    ib  = (clb_p1_q == CLS_INF);
    za  = (cla_p1_q == CLS_ZERO);
    zb  = (clb_p1_q == CLS_ZERO);
    res_d = '0;
    spc_d = 1'b1;
    inv_d = 1'b0;
    case (op_p1_q)
      OP_ADD, OP_SUB: begin
        if (na || nb) res_d = QNAN;
        else if (ia && ib) begin
          if (sa == sbe) res_d = {sa, INF_MAG};
          else begin
            res_d = QNAN;
            inv_d = 1'b1;
          end
        end
        else if (ia)       res_d = {sa, INF_MAG};
        else if (ib)       res_d = {sbe, b_p1_q[W-2:0]};
        else if (za && zb) res_d = {sa & sbe, {(W-1){1'b0}}};
        else if (za)       res_d = {sbe, b_p1_q[W-2:0]};
        else if (zb)       res_d = a_p1_q;
        else               spc_d = 1'b0;
      end
      OP_MUL: begin
        if (na || nb) res_d = QNAN;
        else if ((ia && zb) || (za && ib)) begin
          res_d = QNAN;
          inv_d = 1'b1;
        end
        else if (ia || ib) res_d = {sm, INF_MAG};
        else if (za || zb) res_d = {sm, {(W-1){1'b0}}};
        else               spc_d = 1'b0;
      end
      default: begin
        res_d = QNAN;
        inv_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (acc_in)      vld_p1_d = 1'b1;
    else if (adv_p2) vld_p1_d = 1'b0;
    vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (flag_clr) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
    if (acc_out && inv_p2_q) flag_d = 1'b1;
    if (acc_out && spc_p2_q) cnt_d = sat_inc(cnt_d);
  end

  // Stage 2: register the resolved beat; outputs must read zero during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      spc_p2_q <= 1'b0;
      inv_p2_q <= 1'b0;
      cla_p2_q <= '0;
      clb_p2_q <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      if (adv_p2 && vld_p1_q) begin
        res_p2_q <= spc_d ? res_d : '0;
        spc_p2_q <= spc_d;
        inv_p2_q <= inv_d;
        cla_p2_q <= cla_p1_q;
        clb_p2_q <= clb_p1_q;
      end
    end
  end

  assign out_valid    = vld_p2_q;
  assign out_result   = res_p2_q;
  assign out_special  = spc_p2_q;
  assign out_invalid  = inv_p2_q;
  assign out_class_a  = cla_p2_q;
  assign out_class_b  = clb_p2_q;
  assign flag_invalid = flag_q;
  assign special_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Scoreboard bench for fp_special_pipe: directed operand pairs with hand-derived
// results, a decoupled output monitor, backpressure, sticky flag/counter and reset.
module tb_fp_special_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int CNT_W = 16;
  localparam int W     = 32;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         spc;
    logic         inv;
    logic [2:0]   ca;
    logic [2:0]   cb;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         spc;
    logic         inv;
    logic [2:0]   ca;
    logic [2:0]   cb;
  } beat_t;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     a, b, out_result;
  logic [1:0]       op;
  logic             out_special, out_invalid, flag_invalid, flag_clr;
  logic [2:0]       out_class_a, out_class_b;
  logic [CNT_W-1:0] special_cnt;

  vec_t  tbl [16];
  beat_t sb_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  fp_special_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_special(out_special), .out_invalid(out_invalid),
    .out_class_a(out_class_a), .out_class_b(out_class_b),
    .flag_invalid(flag_invalid), .flag_clr(flag_clr), .special_cnt(special_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    beat_t e;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (in_ready) begin
        e = '{v.res, v.spc, v.inv, v.ca, v.cb};
        sb_q.push_back(e);
        @(negedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: in_ready stayed low for a=%h b=%h", v.a, v.b);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb_q.size() == 0) return;
      @(negedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL drain_timeout: %0d beats still expected", sb_q.size());
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    @(negedge clk); #1;
    flag_clr = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each consumed beat, checks stall hold
  initial begin
    beat_t got, exp, prev;
    logic  stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      got = '{out_result, out_special, out_invalid, out_class_a, out_class_b};
      if (stall) chk("stall_hold", got, prev);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", got);
        end else begin
          exp = sb_q.pop_front();
          chk("beat", got, exp);
        end
      end
      stall = out_valid && !out_ready;
      prev  = got;
    end
  end

  initial begin
    int exp_cnt;
    //          op     a             b             result        spc   inv   ca      cb
    tbl[0]  = '{2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b1, 3'b100, 3'b100};
    tbl[1]  = '{2'b10, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b1, 3'b000, 3'b100};
    tbl[2]  = '{2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 1'b0, 3'b000, 3'b011};
    tbl[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[4]  = '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[5]  = '{2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[6]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 3'b011, 3'b011};
    tbl[7]  = '{2'b00, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3'b011, 3'b011};
    tbl[8]  = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 3'b011, 3'b100};
    tbl[9]  = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 3'b110, 3'b011};
    tbl[10] = '{2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b1, 3'b011, 3'b011};
`ifdef FP_SUBNORMAL_FLUSH_EN
    tbl[11] = '{2'b10, 32'h00000001, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b1, 3'b000, 3'b100};
`else
    tbl[11] = '{2'b10, 32'h00000001, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 3'b001, 3'b100};
`endif
    tbl[12] = '{2'b00, 32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 3'b100, 3'b100};
    tbl[13] = '{2'b01, 32'h40000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0, 3'b011, 3'b000};
    tbl[14] = '{2'b10, 32'hC0000000, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0, 3'b011, 3'b100};
    tbl[15] = '{2'b00, 32'h80000000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 3'b000, 3'b011};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    out_ready = 1'b1; flag_clr = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_flag", flag_invalid, 0);
    chk("rst_cnt", special_cnt, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    @(negedge clk); #1;

    // Back-to-back directed vectors
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i]);
      if (tbl[i].spc) exp_cnt++;
    end
    drain();
    chk("flag_after_stream", flag_invalid, 1);
    chk("cnt_after_stream", special_cnt, exp_cnt);

    pulse_clr();
    chk("flag_cleared", flag_invalid, 0);
    chk("cnt_cleared", special_cnt, 0);

    // Backpressure: only two pairs fit while the output is stalled
    out_ready = 1'b0;
    send(tbl[6]);
    send(tbl[8]);
    a = tbl[13].a; b = tbl[13].b; op = tbl[13].op; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    send(tbl[13]);
    send(tbl[15]);
    drain();

    // Counter clear colliding with a fourth special beat
    pulse_clr();
    send(tbl[2]);
    send(tbl[3]);
    send(tbl[4]);
    drain();
    chk("cnt_three", special_cnt, 3);
    chk("flag_before_fourth", flag_invalid, 0);
    send(tbl[10]);
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 10) begin
        @(negedge clk); #1;
        waited++;
      end
      if (!out_valid) begin
        n_checks++; n_fail++;
        $display("FAIL fourth_timeout: out_valid %0d required 1", out_valid);
      end
    end
    pulse_clr();
    chk("cnt_clr_with_inc", special_cnt, 1);
    chk("flag_set_wins", flag_invalid, 1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_special", out_special, 0);
    chk("midrst_invalid", out_invalid, 0);
    chk("midrst_classes", {out_class_a, out_class_b}, 0);
    chk("midrst_flag", flag_invalid, 0);
    chk("midrst_cnt", special_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); #1;
    end
    send(tbl[15]);
    drain();
    chk("cnt_after_midrst", special_cnt, 1);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
